// File: rtl/stream_mux_n.sv
// N-to-1 stream multiplexer with a one-word registered output stage.
// Define STREAM_MUX_RR_EN to compile in round-robin arbitration (rr_mode); otherwise fixed select only.
module stream_mux_n #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 32,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      rr_mode,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;
   logic             load;
   logic             xfer;

`ifdef STREAM_MUX_RR_EN
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W:0]   cand;
`else
   logic             unused_rr_mode;
   assign unused_rr_mode = rr_mode;
`endif

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = sel;
`ifdef STREAM_MUX_RR_EN
      cand      = '0;
      if (rr_mode) begin
         grant_idx = '0;
         // Rotating priority: first valid channel strictly after the last granted one.
         for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = {1'b0, rr_ptr} + i[SEL_W:0];
            if (cand >= CH_L)
               cand = cand - CH_L;
            if (!grant_vld && in_valid[cand[SEL_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = cand[SEL_W-1:0];
            end
         end
      end else begin
         grant_vld = ({1'b0, sel} < CH_L);
      end
`else
      grant_vld = ({1'b0, sel} < CH_L);
`endif
   end

   always_comb begin
      grant_data = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (grant_idx == c[SEL_W-1:0])
            grant_data = in_data[c*WIDTH +: WIDTH];
      end
   end

   assign load = !out_valid || out_ready;
   assign xfer = grant_vld && in_valid[grant_idx] && load && !reset;

   // Ready is driven from grant and load only, never from the channel's own valid in fixed mode.
   always_comb begin
      in_ready = '0;
      if (grant_vld && !reset)
         in_ready[grant_idx] = load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
`ifdef STREAM_MUX_RR_EN
         rr_ptr    <= SEL_W'(CHANNELS - 1);
`endif
      end else if (load) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= grant_data;
            out_chan <= grant_idx;
`ifdef STREAM_MUX_RR_EN
            rr_ptr   <= grant_idx;
`endif
         end
      end
   end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed vector table, hand sequences and randomized run
// against a behavioural model; DUT0 has 32 channels, DUT1 has 20 channels on the low slice.
module tb_stream_mux_n;

`ifdef STREAM_MUX_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [32*64-1:0] in_data;
   logic [31:0]     in_valid;
   logic [4:0]      sel;
   logic            rr_mode;
   logic            out_ready;

   logic [31:0]     in_ready0;
   logic [63:0]     out_data0;
   logic [4:0]      out_chan0;
   logic            out_valid0;

   logic [20*64-1:0] in_data1;
   logic [19:0]     in_valid1;
   logic [19:0]     in_ready1;
   logic [63:0]     out_data1;
   logic [4:0]      out_chan1;
   logic            out_valid1;

   assign in_data1  = in_data[20*64-1:0];
   assign in_valid1 = in_valid[19:0];

   always #5 clk = ~clk;

   stream_mux_n #(.WIDTH(64), .CHANNELS(32)) u_dut0 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
      .sel(sel), .rr_mode(rr_mode), .out_data(out_data0), .out_chan(out_chan0),
      .out_valid(out_valid0), .out_ready(out_ready)
   );

   stream_mux_n #(.WIDTH(64), .CHANNELS(20)) u_dut1 (
      .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .sel(sel), .rr_mode(rr_mode), .out_data(out_data1), .out_chan(out_chan1),
      .out_valid(out_valid1), .out_ready(out_ready)
   );

   int checks = 0;
   int errors = 0;

   bit          m_valid [2];
   logic [63:0] m_data  [2];
   int          m_chan  [2];
   int          m_ptr   [2];
   int          nch     [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Which channel the rules say is granted this cycle (-1 = none).
   function automatic int model_grant(input int d);
      int n;
      n = nch[d];
      if (RR_EN && rr_mode) begin
         for (int k = 1; k <= n; k++) begin
            int c;
            c = (m_ptr[d] + k) % n;
            if (in_valid[c]) return c;
         end
         return -1;
      end
      return (int'(sel) < n) ? int'(sel) : -1;
   endfunction

   task automatic drive(input bit r, input logic [4:0] s, input bit rr, input logic [31:0] v,
                        input logic [63:0] dat, input bit o);
      reset     = r;
      sel       = s;
      rr_mode   = rr;
      in_valid  = v;
      out_ready = o;
      for (int c = 0; c < 32; c++) in_data[c*64 +: 64] = dat + 64'(c);
   endtask

   // Called shortly after inputs settle: checks ready, advances model and DUT one edge, checks outputs.
   task automatic tick();
      int          g [2];
      bit          ld;
      logic [63:0] er;
      for (int d = 0; d < 2; d++) begin
         g[d] = model_grant(d);
         ld   = !m_valid[d] || out_ready;
         er   = (g[d] >= 0 && !reset && ld) ? (64'd1 << g[d]) : 64'd0;
         if (d == 0) chk("in_ready0", {32'd0, in_ready0}, er);
         else        chk("in_ready1", {44'd0, in_ready1}, er);
      end
      for (int d = 0; d < 2; d++) begin
         ld = !m_valid[d] || out_ready;
         if (reset) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_chan[d]  = 0;
            m_ptr[d]   = nch[d] - 1;
         end else if (ld) begin
            if (g[d] >= 0 && in_valid[g[d]]) begin
               m_valid[d] = 1'b1;
               m_data[d]  = in_data[g[d]*64 +: 64];
               m_chan[d]  = g[d];
               m_ptr[d]   = g[d];
            end else begin
               m_valid[d] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid0", {63'd0, out_valid0}, {63'd0, m_valid[0]});
      chk("out_data0",  out_data0, m_data[0]);
      chk("out_chan0",  {59'd0, out_chan0}, 64'(m_chan[0]));
      chk("out_valid1", {63'd0, out_valid1}, {63'd0, m_valid[1]});
      chk("out_data1",  out_data1, m_data[1]);
      chk("out_chan1",  {59'd0, out_chan1}, 64'(m_chan[1]));
   endtask

   typedef struct {
      bit          rst;
      logic [4:0]  s;
      logic [31:0] v;
      logic [63:0] dat;
      bit          ordy;
      logic [31:0] erdy;
      bit          eov;
      logic [63:0] edat;
      logic [4:0]  echan;
   } vec_t;

   vec_t tbl [13];

   initial begin
      nch[0] = 32;
      nch[1] = 20;
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 1'b0;
         m_data[d]  = '0;
         m_chan[d]  = 0;
         m_ptr[d]   = nch[d] - 1;
      end

      //          rst   sel   valid         data         ordy  ready         ov    out_data     chan
      tbl[0]  = '{1'b1, 5'd5, 32'h0,        64'h0,       1'b1, 32'h0,        1'b0, 64'h0,       5'd0};
      tbl[1]  = '{1'b0, 5'd5, 32'h20,       64'hA0,      1'b1, 32'h20,       1'b1, 64'hA5,      5'd5};
      tbl[2]  = '{1'b0, 5'd5, 32'h20,       64'hB0,      1'b0, 32'h0,        1'b1, 64'hA5,      5'd5};
      tbl[3]  = '{1'b0, 5'd5, 32'h20,       64'hC0,      1'b0, 32'h0,        1'b1, 64'hA5,      5'd5};
      tbl[4]  = '{1'b0, 5'd5, 32'h20,       64'hD0,      1'b0, 32'h0,        1'b1, 64'hA5,      5'd5};
      tbl[5]  = '{1'b0, 5'd5, 32'h20,       64'hE0,      1'b1, 32'h20,       1'b1, 64'hE5,      5'd5};
      tbl[6]  = '{1'b0, 5'd5, 32'h0,        64'hF0,      1'b1, 32'h20,       1'b0, 64'hE5,      5'd5};
      tbl[7]  = '{1'b0, 5'd7, 32'h80,       64'h100,     1'b1, 32'h80,       1'b1, 64'h107,     5'd7};
      tbl[8]  = '{1'b0, 5'd7, 32'h80,       64'h200,     1'b1, 32'h80,       1'b1, 64'h207,     5'd7};
      tbl[9]  = '{1'b0, 5'd3, 32'h80,       64'h300,     1'b0, 32'h0,        1'b1, 64'h207,     5'd7};
      tbl[10] = '{1'b0, 5'd3, 32'h88,       64'h400,     1'b1, 32'h8,        1'b1, 64'h403,     5'd3};
      tbl[11] = '{1'b1, 5'd5, 32'h20,       64'h500,     1'b0, 32'h0,        1'b0, 64'h0,       5'd0};
      tbl[12] = '{1'b0, 5'd5, 32'h20,       64'h600,     1'b0, 32'h20,       1'b1, 64'h605,     5'd5};

      drive(1'b1, 5'd0, 1'b0, 32'h0, 64'h0, 1'b1);
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].rst, tbl[i].s, 1'b0, tbl[i].v, tbl[i].dat, tbl[i].ordy);
         #1;
         chk($sformatf("tbl%0d_ready", i), {32'd0, in_ready0}, {32'd0, tbl[i].erdy});
         tick();
         chk($sformatf("tbl%0d_ov", i),   {63'd0, out_valid0}, {63'd0, tbl[i].eov});
         chk($sformatf("tbl%0d_data", i), out_data0, tbl[i].edat);
         chk($sformatf("tbl%0d_chan", i), {59'd0, out_chan0}, {59'd0, tbl[i].echan});
         @(negedge clk);
      end

      // Back-to-back stream on channel 7: one word per edge, no bubble.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 5'd7, 1'b0, 32'h80, 64'(i) - 64'd7, 1'b1);
         #1;
         chk("b2b_ready", {32'd0, in_ready0}, 64'h80);
         tick();
         chk("b2b_ov",   {63'd0, out_valid0}, 64'd1);
         chk("b2b_data", out_data0, 64'(i));
         @(negedge clk);
      end
      drive(1'b0, 5'd7, 1'b0, 32'h0, 64'h0, 1'b1);
      #1;
      tick();
      chk("b2b_drain_ov", {63'd0, out_valid0}, 64'd0);
      @(negedge clk);

      // Out-of-range select on the 20-channel instance grants nothing.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 5'd25, 1'b0, 32'hFFFF_FFFF, 64'h1000, 1'b1);
         #1;
         chk("oor_ready1", {44'd0, in_ready1}, 64'd0);
         tick();
         chk("oor_ov1", {63'd0, out_valid1}, 64'd0);
         @(negedge clk);
      end

`ifdef STREAM_MUX_RR_EN
      drive(1'b1, 5'd9, 1'b1, 32'h8000_0009, 64'h2000, 1'b1);
      #1;
      tick();
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         int exp_ch [3];
         exp_ch = '{0, 3, 31};
         drive(1'b0, 5'd9, 1'b1, 32'h8000_0009, 64'h3000 + 64'(i*64), 1'b1);
         #1;
         tick();
         chk("rr_ov",   {63'd0, out_valid0}, 64'd1);
         chk("rr_chan", {59'd0, out_chan0}, 64'(exp_ch[i%3]));
         @(negedge clk);
      end
      drive(1'b1, 5'd9, 1'b1, 32'h8000_0009, 64'h4000, 1'b1);
      #1;
      chk("rr_rst_ready", {32'd0, in_ready0}, 64'd0);
      tick();
      chk("rr_rst_ov", {63'd0, out_valid0}, 64'd0);
      @(negedge clk);
      drive(1'b0, 5'd9, 1'b1, 32'h8000_0009, 64'h5000, 1'b1);
      #1;
      tick();
      chk("rr_restart_chan", {59'd0, out_chan0}, 64'd0);
      @(negedge clk);
`endif

      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         rr_mode   = $urandom_range(0, 1) == 1;
         sel       = 5'($urandom);
         case ($urandom_range(0, 3))
            0:       in_valid = 32'h0;
            1:       in_valid = $urandom;
            default: in_valid = $urandom & $urandom & $urandom;
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < 32; c++) in_data[c*64 +: 64] = {$urandom, $urandom};
         #1;
         tick();
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
